// File: rtl/topk_rank_server.sv
// Streaming top-K store: keeps the DEPTH largest samples in descending order and serves rank queries.
// Optional macro TOPK_DEDUP_EN drops samples equal to any stored value.
module topk_rank_server #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned IDX_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_req,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic                  rd_hit,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] entry       [DEPTH];
  logic [DATA_WIDTH-1:0] prev_c      [DEPTH];
  logic [DATA_WIDTH-1:0] entry_nxt_c [DEPTH];
  logic [CNT_W-1:0]      pos_c;
  logic                  ins_c;
  logic                  hit_c;
  logic [DATA_WIDTH-1:0] sel_c;

  // Insert position: valid entries >= din stay ahead, so equal values keep arrival order.
  always_comb begin
    pos_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (entry[i] >= din)) pos_c = pos_c + CNT_W'(1);
    end
  end

`ifdef TOPK_DEDUP_EN
  logic dup_c;

  always_comb begin
    dup_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (entry[i] == din)) dup_c = 1'b1;
    end
  end

  assign ins_c = din_valid && (pos_c < CNT_W'(DEPTH)) && !dup_c;
`else
  assign ins_c = din_valid && (pos_c < CNT_W'(DEPTH));
`endif

  // Shift-insert: below pos keep, at pos take din, above pos take the neighbour above.
  always_comb begin
    prev_c[0] = din;
    for (int i = 1; i < DEPTH; i++) prev_c[i] = entry[i-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < pos_c) entry_nxt_c[i] = entry[i];
      else if (CNT_W'(i) == pos_c) entry_nxt_c[i] = din;
      else entry_nxt_c[i] = prev_c[i];
    end
  end

  // Rank read mux; a hit implies rd_idx < DEPTH because count never exceeds DEPTH.
  always_comb begin
    sel_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (IDX_W'(i) == rd_idx) sel_c = entry[i];
    end
  end

  assign hit_c = CNT_W'(rd_idx) < count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_hit  <= hit_c;
        rd_data <= hit_c ? sel_c : '0;
      end
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
        count <= '0;
      end else if (ins_c) begin
        for (int i = 0; i < DEPTH; i++) entry[i] <= entry_nxt_c[i];
        if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_topk_rank_server.sv
// Bench for topk_rank_server: directed vector table, corner sequences, and random traffic vs. a queue model.
module tb_topk_rank_server;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 2;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          resetn, clear, din_valid, rd_req;
  logic [DW-1:0] din;
  logic [IW-1:0] rd_idx;
  logic          rd_valid, rd_hit;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  topk_rank_server #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_hit(rd_hit),
    .rd_data(rd_data), .count(count)
  );

  typedef struct {
    bit cl; bit dv; int d; bit rq; int idx;
    bit ev; bit eh; int ed; int ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit cl, bit dv, int d, bit rq, int idx, bit ev, bit eh, int ed, int ec);
    vec_t r;
    r.cl = cl; r.dv = dv; r.d = d; r.rq = rq; r.idx = idx;
    r.ev = ev; r.eh = eh; r.ed = ed; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input bit rn, input bit cl, input bit dv, input int d, input bit rq, input int idx);
    resetn    = rn;
    clear     = cl;
    din_valid = dv;
    din       = DW'(d);
    rd_req    = rq;
    rd_idx    = IW'(idx);
    @(posedge clk);
    #1;
  endtask

  // Reference model: sorted queue of valid values, largest first.
  int mq[$];
  bit m_hit;
  int m_data;

  task automatic model_cycle(input bit rn, input bit cl, input bit dv, input int d,
                             input bit rq, input int idx, output bit ev);
    int  pos;
    bit  dup;
    ev = 1'b0;
    if (!rn) begin
      mq.delete();
      m_hit  = 1'b0;
      m_data = 0;
      return;
    end
    if (rq) begin
      ev     = 1'b1;
      m_hit  = idx < mq.size();
      m_data = m_hit ? mq[idx] : 0;
    end
    if (cl) begin
      mq.delete();
    end else if (dv) begin
      pos = 0;
      dup = 1'b0;
      foreach (mq[i]) begin
        if (mq[i] >= d) pos++;
        if (mq[i] == d) dup = 1'b1;
      end
`ifndef TOPK_DEDUP_EN
      dup = 1'b0;
`endif
      if (!dup && pos < DEPTH) begin
        mq.insert(pos, d);
        if (mq.size() > DEPTH) void'(mq.pop_back());
      end
    end
  endtask

  initial begin
    bit ev;
    bit rn, cl, dv, rq;
    int d, idx;

    resetn = 1'b0; clear = 1'b0; din_valid = 1'b0; din = '0; rd_req = 1'b0; rd_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(rd_valid), 0);
    chk("reset_hit",   int'(rd_hit), 0);
    chk("reset_data",  int'(rd_data), 0);
    chk("reset_count", int'(count), 0);

    // Directed table: {clear, din_valid, din, rd_req, rd_idx, exp valid, hit, data, count}
    tbl.push_back(v(0, 0,   0, 1, 0, 1, 0,   0, 0));
    tbl.push_back(v(0, 1,   5, 0, 0, 0, 0,   0, 1));
    tbl.push_back(v(0, 1,   9, 0, 0, 0, 0,   0, 2));
    tbl.push_back(v(0, 1,   3, 0, 0, 0, 0,   0, 3));
    tbl.push_back(v(0, 1,   7, 0, 0, 0, 0,   0, 4));
    tbl.push_back(v(0, 0,   0, 1, 0, 1, 1,   9, 4));
    tbl.push_back(v(0, 0,   0, 1, 1, 1, 1,   7, 4));
    tbl.push_back(v(0, 0,   0, 1, 2, 1, 1,   5, 4));
    tbl.push_back(v(0, 0,   0, 1, 3, 1, 1,   3, 4));
    tbl.push_back(v(0, 1,   1, 1, 3, 1, 1,   3, 4));
    tbl.push_back(v(0, 0,   0, 1, 3, 1, 1,   3, 4));
    tbl.push_back(v(0, 1,   8, 0, 0, 0, 1,   3, 4));
    tbl.push_back(v(0, 0,   0, 1, 0, 1, 1,   9, 4));
    tbl.push_back(v(0, 0,   0, 1, 1, 1, 1,   8, 4));
    tbl.push_back(v(0, 0,   0, 1, 2, 1, 1,   7, 4));
    tbl.push_back(v(0, 0,   0, 1, 3, 1, 1,   5, 4));
    tbl.push_back(v(0, 1,  10, 1, 0, 1, 1,   9, 4));
    tbl.push_back(v(0, 0,   0, 1, 0, 1, 1,  10, 4));
    tbl.push_back(v(0, 0,   0, 1, 3, 1, 1,   7, 4));
    tbl.push_back(v(1, 1,  50, 1, 0, 1, 1,  10, 0));
    tbl.push_back(v(0, 0,   0, 1, 0, 1, 0,   0, 0));
    tbl.push_back(v(0, 1, 255, 0, 0, 0, 0,   0, 1));
    tbl.push_back(v(0, 1,   0, 0, 0, 0, 0,   0, 2));
    tbl.push_back(v(0, 0,   0, 1, 0, 1, 1, 255, 2));
    tbl.push_back(v(0, 0,   0, 1, 1, 1, 1,   0, 2));
    tbl.push_back(v(0, 0,   0, 1, 2, 1, 0,   0, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(1'b1, tbl[i].cl, tbl[i].dv, tbl[i].d, tbl[i].rq, tbl[i].idx);
      chk($sformatf("tbl%0d_valid", i), int'(rd_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_hit", i),   int'(rd_hit),   int'(tbl[i].eh));
      chk($sformatf("tbl%0d_data", i),  int'(rd_data),  tbl[i].ed);
      chk($sformatf("tbl%0d_count", i), int'(count),    tbl[i].ec);
    end

    // Duplicate handling after reset
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b1, 6, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b1, 6, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, 1);
`ifdef TOPK_DEDUP_EN
    chk("dup_count", int'(count), 1);
    chk("dup_hit",   int'(rd_hit), 0);
    chk("dup_data",  int'(rd_data), 0);
`else
    chk("dup_count", int'(count), 2);
    chk("dup_hit",   int'(rd_hit), 1);
    chk("dup_data",  int'(rd_data), 6);
`endif

    // Query followed by reset with clear/din/rd_req also asserted
    cyc(1'b1, 1'b0, 1'b1, 42, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, 0);
    chk("prerst_valid", int'(rd_valid), 1);
    chk("prerst_data",  int'(rd_data), 42);
    cyc(1'b0, 1'b1, 1'b1, 77, 1'b1, 0);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_hit",   int'(rd_hit), 0);
    chk("rst_data",  int'(rd_data), 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    chk("postrst_novalid", int'(rd_valid), 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, 0);
    chk("postrst_valid", int'(rd_valid), 1);
    chk("postrst_hit",   int'(rd_hit), 0);

    // Random traffic against the queue model
    model_cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, ev);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    for (int n = 0; n < 3000; n++) begin
      rn  = ($urandom_range(0, 199) != 0);
      cl  = ($urandom_range(0, 59) == 0);
      dv  = ($urandom_range(0, 2) != 0);
      d   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      rq  = ($urandom_range(0, 1) != 0);
      idx = int'($urandom_range(0, DEPTH - 1));
      model_cycle(rn, cl, dv, d, rq, idx, ev);
      cyc(rn, cl, dv, d, rq, idx);
      chk($sformatf("rnd%0d_valid", n), int'(rd_valid), int'(ev));
      chk($sformatf("rnd%0d_hit", n),   int'(rd_hit),   int'(m_hit));
      chk($sformatf("rnd%0d_data", n),  int'(rd_data),  m_data);
      chk($sformatf("rnd%0d_count", n), int'(count),    mq.size());
    end

    resetn = 1'b1; clear = 1'b0; din_valid = 1'b0; rd_req = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
